// File: rtl/rr_lock_arbiter_pkg.sv
// Shared types and layout helpers for the transaction-locking round-robin arbiter.
package rr_lock_arbiter_pkg;

   // Arbitration state: FREE picks a new winner, LOCKED holds the current owner.
   typedef enum logic {
      FREE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Width of a source index; never zero so NUM=1 still has a 1-bit index.
   function automatic int ctrl_w(input int num);
      return (num <= 2) ? 1 : $clog2(num);
   endfunction

   // Output word layout: payload sits at bit 0, the source index directly above it.
   localparam int PAYLOAD_LSB = 0;

   function automatic int src_idx_lsb(input int din);
      return din;
   endfunction

endpackage

// File: rtl/rr_lock_arbiter_pick.sv
// Cyclic priority encoder: first asserted request at or after ptr, wrapping at NUM.
module rr_pick
   import rr_lock_arbiter_pkg::*;
#(
   parameter int NUM    = 4,
   parameter int CTRL_W = 2
) (
   input  logic [NUM-1:0]    req,
   input  logic [CTRL_W-1:0] ptr,
   output logic [CTRL_W-1:0] idx,
   output logic              any
);

   // Walk the request vector starting at ptr and keep the first hit.
   always_comb begin
      int cand;
      cand = 0;
      idx  = '0;
      any  = 1'b0;
      for (int k = 0; k < NUM; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NUM) cand = cand - NUM;
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = CTRL_W'(cand);
         end
      end
   end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that merges NUM valid/ready producers into one consumer,
// holding the grant for a whole transaction (up to the eot beat).
module rr_lock_arbiter
   import rr_lock_arbiter_pkg::*;
#(
   parameter  int NUM      = 4,
   parameter  int DIN      = 16,
   parameter  bit EOT_LOCK = 1'b1,
   localparam int CTRL_W   = ctrl_w(NUM)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM-1:0]        din_valid,
   output logic [NUM-1:0]        din_ready,
   input  logic [NUM*DIN-1:0]    din_data,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic [DIN+CTRL_W-1:0] dout_data
);

   localparam int SRC_LSB = src_idx_lsb(DIN);

   arb_state_t        state, state_nxt;
   logic [CTRL_W-1:0] ptr, ptr_nxt;
   logic [CTRL_W-1:0] lock_idx, lock_idx_nxt;

   logic [CTRL_W-1:0] pick_idx;
   logic              pick_any;
   logic [CTRL_W-1:0] g;
   logic              active;
   logic [DIN-1:0]    sel_data;
   logic              accept;
   logic              eot;

   // Next priority pointer after index v, wrapping at NUM (also for non-power-of-2 NUM).
   function automatic logic [CTRL_W-1:0] wrap_inc(input logic [CTRL_W-1:0] v);
      if (int'(v) >= NUM - 1) return '0;
      return v + 1'b1;
   endfunction

   rr_pick #(
      .NUM    (NUM),
      .CTRL_W (CTRL_W)
   ) u_pick (
      .req (din_valid),
      .ptr (ptr),
      .idx (pick_idx),
      .any (pick_any)
   );

   // Current grant: round-robin pick when free, the locked owner otherwise.
   always_comb begin
      g      = pick_idx;
      active = pick_any;
      if (state == LOCKED) begin
         g      = lock_idx;
         active = 1'b0;
         for (int i = 0; i < NUM; i++) begin
            if (lock_idx == CTRL_W'(i)) active = din_valid[i];
         end
      end
      sel_data = '0;
      for (int i = 0; i < NUM; i++) begin
         if (g == CTRL_W'(i)) sel_data = din_data[i*DIN +: DIN];
      end
   end

   // Arbitration state register; reset abandons any open transaction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= FREE;
         ptr      <= '0;
         lock_idx <= '0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         lock_idx <= lock_idx_nxt;
      end
   end

   // Next-state logic: lock on the first offered beat, release on an accepted eot.
   always_comb begin
      state_nxt    = state;
      ptr_nxt      = ptr;
      lock_idx_nxt = lock_idx;
      case (state)
         FREE: begin
            if (accept && eot) begin
               ptr_nxt = wrap_inc(g);
            end else if (active) begin
               // Either a multi-beat packet started or the beat is stalled:
               // freeze the grant so the offered data cannot change.
               state_nxt    = LOCKED;
               lock_idx_nxt = g;
            end
         end
         LOCKED: begin
            if (accept && eot) begin
               state_nxt = FREE;
               ptr_nxt   = wrap_inc(lock_idx);
            end
         end
         default: state_nxt = FREE;
      endcase
   end

   // Combinational outputs; nothing is offered or readied while rst is high.
   always_comb begin
      dout_valid = active & ~rst;
      accept     = dout_valid & dout_ready;
      eot        = sel_data[DIN-1] | (EOT_LOCK == 1'b0);
      for (int i = 0; i < NUM; i++) begin
         din_ready[i] = dout_ready & active & (g == CTRL_W'(i)) & ~rst;
      end
      dout_data                        = '0;
      dout_data[PAYLOAD_LSB +: DIN]    = sel_data;
      dout_data[SRC_LSB +: CTRL_W]     = g;
   end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Bench for rr_lock_arbiter: directed scenarios plus randomized traffic on a
// NUM=4/EOT_LOCK=1 instance and a NUM=3/EOT_LOCK=0 instance, both checked
// against an ownership-based reference model.
module tb_rr_lock_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // NUM=4, DIN=16, EOT_LOCK=1
   logic [3:0]  v4;
   logic [15:0] d4 [4];
   logic        r4;
   logic [63:0] din_data4;
   logic [3:0]  din_ready4;
   logic        dout_valid4;
   logic [17:0] dout_data4;
   assign din_data4 = {d4[3], d4[2], d4[1], d4[0]};

   // NUM=3, DIN=16, EOT_LOCK=0
   logic [2:0]  v3;
   logic [15:0] d3 [3];
   logic        r3;
   logic [47:0] din_data3;
   logic [2:0]  din_ready3;
   logic        dout_valid3;
   logic [17:0] dout_data3;
   assign din_data3 = {d3[2], d3[1], d3[0]};

   rr_lock_arbiter #(.NUM(4), .DIN(16), .EOT_LOCK(1'b1)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (v4),
      .din_ready  (din_ready4),
      .din_data   (din_data4),
      .dout_valid (dout_valid4),
      .dout_ready (r4),
      .dout_data  (dout_data4)
   );

   rr_lock_arbiter #(.NUM(3), .DIN(16), .EOT_LOCK(1'b0)) u_dut3 (
      .clk        (clk),
      .rst        (rst),
      .din_valid  (v3),
      .din_ready  (din_ready3),
      .din_data   (din_data3),
      .dout_valid (dout_valid3),
      .dout_ready (r3),
      .dout_data  (dout_data3)
   );

   int    n_tests = 0;
   int    n_fail  = 0;
   string phase   = "init";

   // Reference model: a source "owns" the channel from its first offered beat
   // until its eot beat is taken; with no owner, the first valid source at or
   // after prio (cyclically) is chosen.
   int num_of [2] = '{4, 3};
   bit eotl   [2] = '{1'b1, 1'b0};
   int owner  [2] = '{-1, -1};
   int prio   [2] = '{0, 0};
   bit m_act  [2] = '{1'b0, 1'b0};
   int m_g    [2] = '{0, 0};

   function automatic bit vbit(input int inst, input int i);
      return (inst == 0) ? v4[i] : v3[i];
   endfunction

   function automatic logic [15:0] dword(input int inst, input int i);
      return (inst == 0) ? d4[i] : d3[i];
   endfunction

   function automatic bit rdy(input int inst);
      return (inst == 0) ? r4 : r3;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", phase, tag, obs, exp);
      end
   endtask

   task automatic model_eval();
      for (int inst = 0; inst < 2; inst++) begin
         m_act[inst] = 1'b0;
         m_g[inst]   = 0;
         if (owner[inst] >= 0) begin
            m_g[inst]   = owner[inst];
            m_act[inst] = vbit(inst, owner[inst]);
         end else begin
            for (int k = 0; k < num_of[inst]; k++) begin
               int c;
               c = (prio[inst] + k) % num_of[inst];
               if (!m_act[inst] && vbit(inst, c)) begin
                  m_act[inst] = 1'b1;
                  m_g[inst]   = c;
               end
            end
         end
      end
   endtask

   // Sample and compare both instances mid-cycle.
   task automatic chk();
      @(negedge clk);
      model_eval();
      for (int inst = 0; inst < 2; inst++) begin
         int   ev, er, ed;
         logic ov;
         logic [31:0] orr, od;
         ev = (m_act[inst] && !rst) ? 1 : 0;
         er = (ev != 0 && rdy(inst)) ? (1 << m_g[inst]) : 0;
         ed = (m_g[inst] << 16) | int'(dword(inst, m_g[inst]));
         ov  = (inst == 0) ? dout_valid4 : dout_valid3;
         orr = (inst == 0) ? 32'(din_ready4) : 32'(din_ready3);
         od  = (inst == 0) ? 32'(dout_data4) : 32'(dout_data3);
         check((inst == 0) ? "n4_valid" : "n3_valid", 32'(ov), 32'(ev));
         check((inst == 0) ? "n4_ready" : "n3_ready", orr, 32'(er));
         if (ev != 0) check((inst == 0) ? "n4_data" : "n3_data", od, 32'(ed));
      end
   endtask

   // Advance the model across the clock edge, then release the inputs for driving.
   task automatic tick();
      @(posedge clk);
      for (int inst = 0; inst < 2; inst++) begin
         logic [15:0] w;
         bit          e;
         w = dword(inst, m_g[inst]);
         e = w[15] || !eotl[inst];
         if (rst) begin
            owner[inst] = -1;
            prio[inst]  = 0;
         end else if (m_act[inst] && rdy(inst) && e) begin
            owner[inst] = -1;
            prio[inst]  = (m_g[inst] + 1) % num_of[inst];
         end else if (m_act[inst]) begin
            owner[inst] = m_g[inst];
         end
      end
      #1;
   endtask

   initial begin
      rst = 1'b1;
      v4  = 4'hF;
      r4  = 1'b1;
      v3  = 3'b0;
      r3  = 1'b0;
      for (int i = 0; i < 4; i++) d4[i] = 16'h8000 | 16'(i);
      for (int i = 0; i < 3; i++) d3[i] = 16'h0;

      // Reset: requests present but nothing may be offered or readied.
      phase = "reset";
      tick();
      chk();
      check("rst_valid", 32'(dout_valid4), 32'd0);
      check("rst_ready", 32'(din_ready4), 32'd0);
      tick();
      rst = 1'b0;

      // All four sources with single-beat packets: 0,1,2,3,0.
      phase = "rr4";
      for (int k = 0; k < 5; k++) begin
         v4 = 4'hF;
         r4 = 1'b1;
         for (int i = 0; i < 4; i++) d4[i] = 16'h8000 | 16'(i * 16 + k);
         chk();
         check("rr_src", 32'(dout_data4[17:16]), 32'(k % 4));
         check("rr_ready", 32'(din_ready4), 32'(1 << (k % 4)));
         tick();
      end
      v4 = 4'h0;
      chk();
      tick();

      // Source 1 three-beat packet while source 2 waits.
      phase = "lock3";
      for (int b = 0; b < 3; b++) begin
         v4    = 4'b0110;
         d4[1] = {(b == 2), 15'(16'h100 + b)};
         d4[2] = 16'h8200;
         chk();
         check("pkt_src", 32'(dout_data4[17:16]), 32'd1);
         check("pkt_loser_rdy", 32'(din_ready4[2]), 32'd0);
         tick();
      end
      v4 = 4'b0100;
      chk();
      check("pkt_next_src", 32'(dout_data4[17:16]), 32'd2);
      tick();

      // Backpressure: offered grant stays fixed even when a higher-priority source appears.
      phase = "stall";
      v4    = 4'b0001;
      d4[0] = 16'h8abc;
      d4[3] = 16'h8333;
      r4    = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk();
         check("stall_data", 32'(dout_data4), {14'd0, 2'd0, 16'h8abc});
         check("stall_ready", 32'(din_ready4), 32'd0);
         tick();
      end
      v4 = 4'b1001;
      r4 = 1'b1;
      chk();
      check("stall_first", 32'(dout_data4[17:16]), 32'd0);
      check("stall_first_rdy", 32'(din_ready4), 32'b0001);
      tick();
      v4 = 4'b1000;
      chk();
      check("stall_then3", 32'(dout_data4), {14'd0, 2'd3, 16'h8333});
      tick();

      // Bubble inside a locked packet from source 2; source 0 must wait.
      phase = "bubble";
      v4    = 4'b0100;
      d4[2] = 16'h0222;
      d4[0] = 16'h8000;
      chk();
      check("bub_start", 32'(dout_data4[17:16]), 32'd2);
      tick();
      for (int k = 0; k < 2; k++) begin
         v4 = 4'b0001;
         chk();
         check("bub_valid", 32'(dout_valid4), 32'd0);
         check("bub_ready", 32'(din_ready4), 32'd0);
         tick();
      end
      v4    = 4'b0101;
      d4[2] = 16'h8223;
      chk();
      check("bub_resume", 32'(dout_data4), {14'd0, 2'd2, 16'h8223});
      tick();
      v4 = 4'b0001;
      chk();
      check("bub_after", 32'(dout_data4[17:16]), 32'd0);
      tick();

      // Reset in the middle of source 1's packet.
      phase = "midrst";
      v4    = 4'b0010;
      d4[1] = 16'h0111;
      chk();
      check("mr_src", 32'(dout_data4[17:16]), 32'd1);
      tick();
      rst = 1'b1;
      v4  = 4'b0011;
      chk();
      check("mr_valid", 32'(dout_valid4), 32'd0);
      tick();
      rst   = 1'b0;
      d4[0] = 16'h8001;
      d4[1] = 16'h0112;
      chk();
      check("mr_winner", 32'(dout_data4[17:16]), 32'd0);
      tick();
      v4 = 4'b0000;
      chk();
      tick();

      // EOT_LOCK=0, NUM=3: multi-beat data from 0 and 2 interleaves, ptr wraps 2->0.
      phase = "noeot3";
      for (int k = 0; k < 4; k++) begin
         v3 = 3'b101;
         r3 = 1'b1;
         d3[0] = 16'h0a00 | 16'(k);
         d3[2] = 16'h0c00 | 16'(k);
         chk();
         check("n3_src", 32'(dout_data3[17:16]), 32'((k % 2) * 2));
         check("n3_rdy", 32'(din_ready3), (k % 2 == 0) ? 32'b001 : 32'b100);
         tick();
      end

      // Randomized traffic on both instances, including stalls, bubbles and resets.
      phase = "random";
      for (int n = 0; n < 400; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         for (int i = 0; i < 4; i++) begin
            v4[i] = ($urandom_range(0, 9) < 7);
            d4[i] = {($urandom_range(0, 2) == 0), 15'($urandom)};
         end
         for (int i = 0; i < 3; i++) begin
            v3[i] = ($urandom_range(0, 9) < 7);
            d3[i] = {($urandom_range(0, 2) == 0), 15'($urandom)};
         end
         r4 = ($urandom_range(0, 3) != 0);
         r3 = ($urandom_range(0, 3) != 0);
         chk();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
